// File: rtl/traffic_signal_sequencer.sv
// Demand-actuated round-robin traffic signal sequencer for 2..8 conflicting phases.
// Optional pedestrian all-walk interval is compiled in with `define PED_WALK_EN.
module traffic_signal_sequencer #(
  parameter int NUM_PHASES    = 4,
  parameter int GREEN_CYCLES  = 20,
  parameter int YELLOW_CYCLES = 4,
  parameter int ALLRED_CYCLES = 2,
  parameter int WALK_CYCLES   = 10,
  parameter int CNT_W         = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_PHASES-1:0]         i_veh_req,
  input  logic                          i_ped_req,
  output logic [NUM_PHASES-1:0]         o_red,
  output logic [NUM_PHASES-1:0]         o_yellow,
  output logic [NUM_PHASES-1:0]         o_green,
  output logic                          o_walk,
  output logic [$clog2(NUM_PHASES)-1:0] o_phase
);

  localparam int PW = $clog2(NUM_PHASES);
  localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(ALLRED_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_WALK   = CNT_W'(WALK_CYCLES - 1);

  typedef enum logic [1:0] {S_ALLRED, S_GREEN, S_YELLOW, S_WALK} state_e;

  state_e                r_state, w_nextState;
  logic [CNT_W-1:0]      r_timer, w_nextTimer;
  logic [PW-1:0]         r_phase, w_nextPhase, w_selPhase;
  logic [NUM_PHASES-1:0] r_dem, w_nextDem;
  logic                  w_expired, w_otherDem, w_pedPend, w_enterGreen;
  logic [NUM_PHASES-1:0] w_red, w_yellow, w_green;
  logic                  w_walk;

`ifdef PED_WALK_EN
  logic r_pedPend;

  // Entering WALK serves the pending request; later presses re-arm it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_pedPend <= 1'b0;
    else if (w_nextState == S_WALK && r_state != S_WALK)
      r_pedPend <= 1'b0;
    else if (i_ped_req)
      r_pedPend <= 1'b1;
  end

  assign w_pedPend = r_pedPend;
`else
  logic w_unusedPed;
  assign w_unusedPed = i_ped_req;
  assign w_pedPend   = 1'b0;
`endif

  assign w_expired  = (r_timer == '0);
  assign w_otherDem = |(r_dem & ~(NUM_PHASES'(1) << r_phase));

  // Nearest demanding phase after the current one; own phase last, recall if none.
  always_comb begin
    logic [PW-1:0] v_idx;
    v_idx      = '0;
    w_selPhase = PW'((int'(r_phase) + 1) % NUM_PHASES);
    for (int k = NUM_PHASES; k >= 1; k--) begin
      v_idx = PW'((int'(r_phase) + k) % NUM_PHASES);
      if (r_dem[v_idx])
        w_selPhase = v_idx;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_ALLRED;
      r_timer  <= LD_ALLRED;
      r_phase  <= PW'(NUM_PHASES - 1);
      r_dem    <= '0;
      o_red    <= '1;
      o_yellow <= '0;
      o_green  <= '0;
      o_walk   <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_timer  <= w_nextTimer;
      r_phase  <= w_nextPhase;
      r_dem    <= w_nextDem;
      o_red    <= w_red;
      o_yellow <= w_yellow;
      o_green  <= w_green;
      o_walk   <= w_walk;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_ALLRED:
        if (w_expired) begin
`ifdef PED_WALK_EN
          w_nextState = w_pedPend ? S_WALK : S_GREEN;
`else
          w_nextState = S_GREEN;
`endif
        end
      S_GREEN:
        if (w_expired && (w_otherDem || w_pedPend))
          w_nextState = S_YELLOW;
      S_YELLOW:
        if (w_expired)
          w_nextState = S_ALLRED;
`ifdef PED_WALK_EN
      S_WALK:
        if (w_expired)
          w_nextState = S_GREEN;
`endif
      default:
        w_nextState = S_ALLRED;
    endcase

    w_enterGreen = (w_nextState == S_GREEN) && (r_state != S_GREEN);
    w_nextPhase  = w_enterGreen ? w_selPhase : r_phase;

    if (w_nextState != r_state) begin
      case (w_nextState)
        S_GREEN:  w_nextTimer = LD_GREEN;
        S_YELLOW: w_nextTimer = LD_YELLOW;
        S_WALK:   w_nextTimer = LD_WALK;
        default:  w_nextTimer = LD_ALLRED;
      endcase
    end else begin
      w_nextTimer = w_expired ? '0 : r_timer - CNT_W'(1);
    end

    // The green phase ignores its own detector; green entry clears the latch.
    for (int i = 0; i < NUM_PHASES; i++) begin
      w_nextDem[i] = r_dem[i] | i_veh_req[i];
      if (r_state == S_GREEN && int'(r_phase) == i)
        w_nextDem[i] = r_dem[i];
      if (w_enterGreen && int'(w_nextPhase) == i)
        w_nextDem[i] = 1'b0;
    end
  end

  always_comb begin
    w_red    = '1;
    w_yellow = '0;
    w_green  = '0;
    w_walk   = 1'b0;
    case (w_nextState)
      S_GREEN: begin
        w_green[w_nextPhase] = 1'b1;
        w_red[w_nextPhase]   = 1'b0;
      end
      S_YELLOW: begin
        w_yellow[w_nextPhase] = 1'b1;
        w_red[w_nextPhase]    = 1'b0;
      end
`ifdef PED_WALK_EN
      S_WALK:   w_walk = 1'b1;
`endif
      default: ;
    endcase
  end

  assign o_phase = r_phase;

endmodule

// File: doc/traffic_signal_sequencer.md
# traffic_signal_sequencer

Parametrised, demand-actuated traffic signal sequencer for 2 to 8 conflicting approaches (phases). It generalises the fixed two-direction NS/EW controller.
- Phases are served round-robin, but only when they have latched vehicle demand.
- The current green rests when no other phase is waiting.
- Every change of right-of-way passes through yellow and an all-red clearance.
- An optional pedestrian all-walk interval can be compiled in.

It sits between the detector and pushbutton synchronisers and the lamp drivers.

## Interface
- NUM_PHASES, 4, number of approaches; legal range 2..8
- GREEN_CYCLES, 20, minimum green duration in clk cycles; range 1..2^CNT_W
- YELLOW_CYCLES, 4, yellow duration in clk cycles; range 1..2^CNT_W
- ALLRED_CYCLES, 2, all-red clearance duration in clk cycles; range 1..2^CNT_W
- WALK_CYCLES, 10, pedestrian walk duration in clk cycles; range 1..2^CNT_W
- CNT_W, 8, width of the interval timer
- clk  input  1  single clock; all state changes on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- veh_req  input  NUM_PHASES  vehicle detector pulses or levels, one bit per phase, already synchronised
- ped_req  input  1  pedestrian pushbutton, already synchronised
- red  output  NUM_PHASES  red lamp per phase
- yellow  output  NUM_PHASES  yellow lamp per phase
- green  output  NUM_PHASES  green lamp per phase
- walk  output  1  pedestrian walk lamp
- phase  output  clog2(NUM_PHASES)  index of the phase most recently granted green

## Operation
- States:
  - ALLRED: all red.
  - GREEN: green[phase].
  - YELLOW: yellow[phase].
  - WALK: all red with walk=1.
- Interval timer:
  - On state entry, load duration-1.
  - Decrement every cycle.
  - An interval expires when the timer is 0.
- Demand latch dem[i]:
  - Set by veh_req[i]=1.
  - Cleared on the edge where phase i enters GREEN.
  - While phase i is GREEN, veh_req[i] is ignored.
  - veh_req[i] in the same cycle as phase i's green entry leaves dem[i]=0.
- Pedestrian latch ped_pend:
  - Set by ped_req=1.
  - Cleared on WALK entry.
  - ped_req during WALK re-latches it.
- GREEN to YELLOW: the timer has expired AND (any dem[j] with j≠phase, OR ped_pend). Otherwise green rests and the condition is re-checked every cycle.
- YELLOW to ALLRED: on expiry.
- ALLRED on expiry:
  - If ped_pend, go to WALK.
  - Otherwise go to GREEN. Next phase is the first j with dem[j]=1, searching phase+1, phase+2, … mod NUM_PHASES.
  - If no demand exists, recall: next phase = phase+1 mod NUM_PHASES.
- WALK to GREEN: on expiry, using the same phase selection.
- Lamps:
  - For every i, exactly one of red[i], yellow[i], green[i] is 1.
  - At most one phase is non-red at any time.
  - walk=1 only in WALK.
- Reset values:
  - State ALLRED with timer = ALLRED_CYCLES-1.
  - phase = NUM_PHASES-1.
  - dem = 0, ped_pend = 0.
  - red = all 1s; yellow, green and walk = 0.

## Timing
- Outputs are registered and change on the same edge as the state.
- Demand sampled on edge k is eligible for the decision taken on edge k+1.
- After rst_n deasserts, green[0] rises on the ALLRED_CYCLES-th rising edge (edge 2 with defaults).
- Each state holds its lamps for exactly its duration in cycles. GREEN holds for at least GREEN_CYCLES.
- Reset asserted mid-operation forces the reset values immediately, without waiting for a clock edge.

## Configuration
- PED_WALK_EN defined:
  - WALK state, ped_pend and the walk output are implemented as described above.
  - ped_pend ends a resting green.
- PED_WALK_EN undefined:
  - ped_req is ignored and walk is tied to 0.
  - The WALK state does not exist.
  - ALLRED always proceeds to GREEN.

## Test plan
- Reset, no requests:
  - red=all 1s during reset.
  - green[0] rises at edge 2 after release and stays 1 for 200 cycles.
- Pulse veh_req[2] at cycle 5, all other inputs idle:
  - green[0] for 20 cycles.
  - yellow[0] at edges 22–25.
  - All-red at edges 26–27.
  - green[2] at edge 28 with phase=2.
- Requests on phases 1 and 3 while phase 0 is green:
  - Service order 1 then 3.
  - Phase 2 is skipped; after 3, green rests.
- PED_WALK_EN defined; ped_req plus veh_req[1] during phase 0 green:
  - Sequence is yellow[0], all-red, then walk=1 for 10 cycles.
  - green[1] follows immediately after WALK.
  - ped_req absent → walk never asserts.
- Assert rst_n=0 mid-yellow:
  - All outputs return to reset values immediately.
  - Latched demand is lost; the sequence restarts with green[0].
- Over the whole run, check every cycle: one lamp per phase, and at most one non-red phase.
